// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states and
// default geometry of the instruction RAM it fills.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DATA  = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam int          DEF_DEPTH_LOG2  = 4;
    localparam logic [31:0] DEF_BASE_ADDR   = 32'h0000_0000;
    localparam int          DEF_TIMEOUT_CYC = 1000;

endpackage

// File: rtl/loader_byte_asm.sv
// Little-endian byte-to-word assembler: collects four accepted bytes and
// presents the finished word with a one-cycle word_ready strobe.
module loader_byte_asm (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_en,
    output logic        word_last,
    output logic        word_ready,
    output logic [31:0] word
);

    logic [23:0] lanes;
    logic [1:0]  cnt;

    assign word_last = byte_en && (cnt == 2'd3);

    // The finished word goes to its own register so the next word's first
    // byte can land in lane 0 during the write cycle without disturbing it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lanes      <= '0;
            cnt        <= '0;
            word_ready <= 1'b0;
            word       <= '0;
        end else begin
            word_ready <= word_last;
            if (byte_en) begin
                cnt <= cnt + 2'd1;
                case (cnt)
                    2'd0:    lanes[7:0]   <= byte_in;
                    2'd1:    lanes[15:8]  <= byte_in;
                    2'd2:    lanes[23:16] <= byte_in;
                    default: word         <= {byte_in, lanes};
                endcase
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-RAM loader: parses COUNT / data / CHK frames from the byte
// link, writes words into RAM and releases the core once the image checks out.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH_LOG2  = DEF_DEPTH_LOG2,
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        we,
    output logic [31:0] wa,
    output logic [31:0] wd,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    localparam int         IW    = DEPTH_LOG2 + 1;
    localparam int         TW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [8:0] MAX_N = 9'(2 ** DEPTH_LOG2);

    state_t          state, state_nx;
    logic [IW-1:0]   n_words, idx;
    logic [7:0]      chk;
    logic [TW-1:0]   idle_cnt;
    logic            fire, asm_en, word_last, count_ok, timed_out, last_word;

    assign fire      = rx_valid && rx_ready;
    assign asm_en    = fire && (state == DATA);
    assign count_ok  = (rx_data != 8'd0) && ({1'b0, rx_data} <= MAX_N);
    assign timed_out = !fire && (idle_cnt == TW'(TIMEOUT_CYC - 1));
    assign last_word = word_last && ((idx + IW'(1)) == n_words);

    loader_byte_asm u_asm (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (rx_data),
        .byte_en    (asm_en),
        .word_last  (word_last),
        .word_ready (we),
        .word       (wd)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (fire) state_nx = count_ok ? DATA : ERR;
            DATA: begin
                if (last_word)      state_nx = CHECK;
                else if (timed_out) state_nx = ERR;
            end
            CHECK: begin
                if (fire)           state_nx = (rx_data == chk) ? DONE : ERR;
                else if (timed_out) state_nx = ERR;
            end
            default: state_nx = state;
        endcase
    end

    assign rx_ready = (state == IDLE) || (state == DATA) || (state == CHECK);
    assign done     = (state == DONE);
    assign err      = (state == ERR);
    assign cpu_hold = (state != DONE);

    // Frame bookkeeping: word count, running XOR, idle watchdog, write address.
    always_ff @(posedge clk) begin
        if (!reset) begin
            n_words  <= '0;
            idx      <= '0;
            chk      <= '0;
            idle_cnt <= '0;
            wa       <= BASE_ADDR;
        end else begin
            case (state)
                IDLE: begin
                    if (fire) begin
                        n_words <= IW'(rx_data);
                        chk     <= rx_data;
                        idx     <= '0;
                    end
                end
                DATA, CHECK: begin
                    idle_cnt <= fire ? '0 : idle_cnt + TW'(1);
                    if (asm_en) chk <= chk ^ rx_data;
                    if (word_last) begin
                        wa  <= BASE_ADDR + 32'({idx, 2'b00});
                        idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: fixed frame table, hand-built corner
// sequences and random frames scored against a frame-level reference model.
module tb_imem_loader;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready, we, cpu_hold, done, err;
    logic [31:0] wa, wd;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] wr_q[$];
    logic [63:0] exp_q[$];
    bit          exp_done, exp_err;

    imem_loader #(
        .DEPTH_LOG2  (4),
        .BASE_ADDR   (32'h0000_0000),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (we) wr_q.push_back({wa, wd});

    typedef struct {
        int          len;
        logic [7:0]  b[12];
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          d;
        bit          e;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wr_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output bit acc);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        acc = rx_ready;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Frame-level reference: which words get written and how the load ends.
    task automatic model(input logic [7:0] fr[$], input int gp[$]);
        int n;
        logic [7:0] x;
        exp_q.delete();
        exp_done = 0;
        exp_err  = 0;
        n = int'(fr[0]);
        if (n < 1 || n > 16) begin
            exp_err = 1;
            return;
        end
        for (int i = 1; i < fr.size(); i++) begin
            if (gp[i] >= TO) begin
                exp_err = 1;
                return;
            end
            if (i <= 4 * n && i % 4 == 0)
                exp_q.push_back({32'(4 * (i / 4 - 1)), fr[i], fr[i-1], fr[i-2], fr[i-3]});
            if (i == 4 * n + 1) begin
                x = 8'h00;
                for (int k = 0; k <= 4 * n; k++) x = x ^ fr[k];
                if (fr[i] == x) exp_done = 1;
                else            exp_err  = 1;
                return;
            end
        end
    endtask

    task automatic cmp_writes(input string tag);
        int m;
        check({tag, "_nwrites"}, 32'(wr_q.size()), 32'(exp_q.size()));
        m = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            check({tag, "_wa"}, wr_q[i][63:32], exp_q[i][63:32]);
            check({tag, "_wd"}, wr_q[i][31:0],  exp_q[i][31:0]);
        end
    endtask

    task automatic check_flags(input string tag, input bit d, input bit e);
        check({tag, "_done"},     32'(done),     32'(d));
        check({tag, "_err"},      32'(err),      32'(e));
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!d));
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bit          acc;
        logic [7:0]  fr[$];
        int          gp[$];
        logic [7:0]  good[10];
        logic [31:0] hold_wa, hold_wd;
        int          n, stall_at;

        good = '{8'h02, 8'h02, 8'h20, 8'h32, 8'hE0, 8'hFD, 8'hFF, 8'hFF, 8'h1A, 8'h15};

        tbl[0] = '{len: 10, b: '{8'h02, 8'h02, 8'h20, 8'h32, 8'hE0, 8'hFD, 8'hFF, 8'hFF, 8'h1A, 8'h15, 8'h00, 8'h00},
                   nw: 2, w0: 32'hE032_2002, w1: 32'h1AFF_FFFD, d: 1, e: 0};
        tbl[1] = '{len: 10, b: '{8'h02, 8'h02, 8'h20, 8'h32, 8'hE0, 8'hFD, 8'hFF, 8'hFF, 8'h1A, 8'h14, 8'h00, 8'h00},
                   nw: 2, w0: 32'hE032_2002, w1: 32'h1AFF_FFFD, d: 0, e: 1};
        tbl[2] = '{len: 1, b: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   nw: 0, w0: 32'h0, w1: 32'h0, d: 0, e: 1};
        tbl[3] = '{len: 1, b: '{8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   nw: 0, w0: 32'h0, w1: 32'h0, d: 0, e: 1};
        tbl[4] = '{len: 6, b: '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   nw: 1, w0: 32'h4433_2211, w1: 32'h0, d: 1, e: 0};

        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rx_ready", 32'(rx_ready), 32'(1));
        check("rst_we",       32'(we),       32'(0));
        check("rst_wa",       wa,            32'h0);
        check("rst_wd",       wd,            32'h0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'(1));
        check("rst_done",     32'(done),     32'(0));
        check("rst_err",      32'(err),      32'(0));
        reset = 1'b1;

        for (int t = 0; t < 5; t++) begin
            do_reset();
            for (int j = 0; j < tbl[t].len; j++) send_byte(tbl[t].b[j], 0, acc);
            check_flags($sformatf("tbl%0d", t), tbl[t].d, tbl[t].e);
            repeat (2) @(negedge clk);
            check($sformatf("tbl%0d_nwrites", t), 32'(wr_q.size()), 32'(tbl[t].nw));
            if (tbl[t].nw >= 1 && wr_q.size() >= 1) begin
                check($sformatf("tbl%0d_wa0", t), wr_q[0][63:32], 32'h0);
                check($sformatf("tbl%0d_wd0", t), wr_q[0][31:0],  tbl[t].w0);
            end
            if (tbl[t].nw >= 2 && wr_q.size() >= 2) begin
                check($sformatf("tbl%0d_wa1", t), wr_q[1][63:32], 32'h4);
                check($sformatf("tbl%0d_wd1", t), wr_q[1][31:0],  tbl[t].w1);
            end
        end

        // Full 16-word image with three idle cycles before every byte.
        do_reset();
        fr.delete(); gp.delete();
        fr.push_back(8'd16); gp.push_back(3);
        for (int i = 0; i < 64; i++) begin fr.push_back(8'($urandom)); gp.push_back(3); end
        fr.push_back(8'h00); gp.push_back(3);
        for (int i = 0; i < 65; i++) fr[65] = fr[65] ^ fr[i];
        model(fr, gp);
        for (int i = 0; i < fr.size(); i++) send_byte(fr[i], gp[i], acc);
        repeat (2) @(negedge clk);
        cmp_writes("full16");
        check_flags("full16", 1, 0);
        if (wr_q.size() == 16) check("full16_last_wa", wr_q[15][63:32], 32'h3C);

        // Stall mid-frame: three idle cycles tolerated, the fourth aborts.
        do_reset();
        send_byte(8'h02, 0, acc);
        send_byte(8'hAA, 0, acc);
        send_byte(8'hBB, 0, acc);
        repeat (3) @(negedge clk);
        check("stall3_err", 32'(err), 32'(0));
        @(negedge clk);
        check("stall4_err",      32'(err),      32'(1));
        check("stall4_cpu_hold", 32'(cpu_hold), 32'(1));

        // Reset after six data bytes, then a clean reload.
        do_reset();
        for (int j = 0; j < 7; j++) send_byte(good[j], 0, acc);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_nwrites", 32'(wr_q.size()), 32'(1));
        if (wr_q.size() >= 1) begin
            check("midrst_wa", wr_q[0][63:32], 32'h0);
            check("midrst_wd", wr_q[0][31:0],  32'hE032_2002);
        end
        check("midrst_err", 32'(err), 32'(0));
        reset = 1'b1;
        wr_q.delete();
        for (int j = 0; j < 10; j++) send_byte(good[j], 0, acc);
        repeat (2) @(negedge clk);
        check("reload_nwrites", 32'(wr_q.size()), 32'(2));
        if (wr_q.size() >= 2) check("reload_wd1", wr_q[1][31:0], 32'h1AFF_FFFD);
        check_flags("reload", 1, 0);

        // Traffic after completion is refused and changes nothing.
        hold_wa = wa;
        hold_wd = wd;
        wr_q.delete();
        for (int j = 0; j < 5; j++) begin
            send_byte(8'($urandom), 0, acc);
            check("postdone_accept", 32'(acc), 32'(0));
        end
        check("postdone_nwrites", 32'(wr_q.size()), 32'(0));
        check("postdone_wa", wa, hold_wa);
        check("postdone_wd", wd, hold_wd);
        check_flags("postdone", 1, 0);

        // Random frames: bad counts, bad checksums, long stalls.
        for (int r = 0; r < 30; r++) begin
            do_reset();
            fr.delete(); gp.delete();
            if ($urandom_range(9) == 0)
                n = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(255, 17));
            else
                n = int'($urandom_range(16, 1));
            fr.push_back(8'(n)); gp.push_back(int'($urandom_range(3)));
            if (n >= 1 && n <= 16) begin
                for (int i = 0; i < 4 * n; i++) begin
                    fr.push_back(8'($urandom)); gp.push_back(int'($urandom_range(3)));
                end
                fr.push_back(8'h00); gp.push_back(int'($urandom_range(3)));
                for (int i = 0; i <= 4 * n; i++) fr[4*n+1] = fr[4*n+1] ^ fr[i];
                if ($urandom_range(3) == 0) fr[4*n+1] = fr[4*n+1] ^ 8'(1 << $urandom_range(7));
                if ($urandom_range(4) == 0) begin
                    stall_at = int'($urandom_range(4 * n + 1, 1));
                    gp[stall_at] = int'($urandom_range(6, TO));
                end
            end
            model(fr, gp);
            for (int i = 0; i < fr.size(); i++) send_byte(fr[i], gp[i], acc);
            repeat (2) @(negedge clk);
            cmp_writes($sformatf("rnd%0d", r));
            check_flags($sformatf("rnd%0d", r), exp_done, exp_err);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
